// File: rtl/fifo_lifo_ctrl.sv
// fifo_lifo_ctrl: initiator-side controller for a FIFO/LIFO storage RAM with registered dataOut.
// Define ALMOST_FLAGS_EN to add the registered almost_full_o/almost_empty_o outputs.
module fifo_lifo_ctrl #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DATA_W = 32
`ifdef ALMOST_FLAGS_EN
   ,
   parameter int unsigned AF_MARGIN = 1,
   parameter int unsigned AE_MARGIN = 1
`endif
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              mode_i,
   input  logic              push_valid_i,
   input  logic [DATA_W-1:0] push_data_i,
   output logic              push_ready_o,
   input  logic              pop_req_i,
   output logic              pop_valid_o,
   output logic [DATA_W-1:0] pop_data_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_din_o,
   output logic              ram_we_o,
   output logic [3:0]        ram_opcode_o,
   input  logic [DATA_W-1:0] ram_dout_i,
   output logic [ADDR_W:0]   count_o,
   output logic              full_o,
   output logic              empty_o,
`ifdef ALMOST_FLAGS_EN
   output logic              almost_full_o,
   output logic              almost_empty_o,
`endif
   output logic              err_underflow_o,
   output logic              err_mode_o
);

   typedef enum logic [1:0] {StIdle, StWrite, StRead, StCapture} state_e;

   localparam logic [ADDR_W:0]   CntFull = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CntOne  = 1;
   localparam logic [ADDR_W-1:0] PtrLast = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] PtrOne  = 1;
   localparam logic [1:0]        OpWrite = 2'b01;
   localparam logic [1:0]        OpRead  = 2'b10;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   sp_q, sp_d, count_q, count_d;
   logic              mode_q, mode_d, mode_err_seen_q;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_din_q, ram_din_d, pop_data_q, pop_data_d;
   logic              ram_we_q, ram_we_d;
   logic [3:0]        ram_opcode_q, ram_opcode_d;
   logic              pop_valid_q, pop_valid_d;
   logic              err_underflow_q, err_underflow_d, err_mode_q, err_mode_d;
   logic              full, empty, idle_empty, mode_eff, pop_accept, mode_mismatch;

   assign full          = (count_q == CntFull);
   assign empty         = (count_q == '0);
   assign idle_empty    = (state_q == StIdle) && empty;
   // While idle and empty the incoming mode is latched this cycle, so a push uses it directly.
   assign mode_eff      = idle_empty ? mode_i : mode_q;
   assign pop_accept    = (state_q == StIdle) && pop_req_i && !empty;
   assign mode_mismatch = (mode_i != mode_q) && !empty;
   assign mode_d        = idle_empty ? mode_i : mode_q;
   assign err_mode_d    = mode_mismatch && !mode_err_seen_q;

   always_comb begin
      state_d         = state_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      sp_d            = sp_q;
      count_d         = count_q;
      ram_addr_d      = ram_addr_q;
      ram_din_d       = ram_din_q;
      ram_we_d        = 1'b0;
      ram_opcode_d    = 4'b0000;
      pop_valid_d     = 1'b0;
      pop_data_d      = pop_data_q;
      err_underflow_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pop_accept) begin
               state_d      = StRead;
               ram_addr_d   = mode_q ? ADDR_W'(sp_q - CntOne) : rd_ptr_q;
               ram_opcode_d = {1'b1, mode_q, OpRead};
            end else if (push_valid_i && !full) begin
               state_d      = StWrite;
               ram_we_d     = 1'b1;
               ram_addr_d   = mode_eff ? sp_q[ADDR_W-1:0] : wr_ptr_q;
               ram_din_d    = push_data_i;
               ram_opcode_d = {1'b1, mode_eff, OpWrite};
            end else if (pop_req_i) begin
               err_underflow_d = 1'b1;
            end
         end
         StWrite: begin
            if (mode_q) sp_d = sp_q + CntOne;
            else        wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
            count_d = count_q + CntOne;
            state_d = StIdle;
         end
         StRead: begin
            if (mode_q) sp_d = sp_q - CntOne;
            else        rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
            count_d = count_q - CntOne;
            state_d = StCapture;
         end
         StCapture: begin
            pop_valid_d = 1'b1;
            pop_data_d  = ram_dout_i;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q         <= StIdle;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         sp_q            <= '0;
         count_q         <= '0;
         mode_q          <= 1'b0;
         mode_err_seen_q <= 1'b0;
         ram_addr_q      <= '0;
         ram_din_q       <= '0;
         ram_we_q        <= 1'b0;
         ram_opcode_q    <= 4'b0000;
         pop_valid_q     <= 1'b0;
         pop_data_q      <= '0;
         err_underflow_q <= 1'b0;
         err_mode_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         sp_q            <= sp_d;
         count_q         <= count_d;
         mode_q          <= mode_d;
         mode_err_seen_q <= mode_mismatch;
         ram_addr_q      <= ram_addr_d;
         ram_din_q       <= ram_din_d;
         ram_we_q        <= ram_we_d;
         ram_opcode_q    <= ram_opcode_d;
         pop_valid_q     <= pop_valid_d;
         pop_data_q      <= pop_data_d;
         err_underflow_q <= err_underflow_d;
         err_mode_q      <= err_mode_d;
      end
   end

`ifdef ALMOST_FLAGS_EN
   localparam logic [ADDR_W:0] AfLevel = (ADDR_W+1)'(DEPTH - AF_MARGIN);
   localparam logic [ADDR_W:0] AeLevel = (ADDR_W+1)'(AE_MARGIN);

   logic almost_full_q, almost_empty_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
      end else begin
         almost_full_q  <= (count_d >= AfLevel);
         almost_empty_q <= (count_d <= AeLevel);
      end
   end

   assign almost_full_o  = almost_full_q;
   assign almost_empty_o = almost_empty_q;
`endif

   assign push_ready_o    = !reset_i && (state_q == StIdle) && !full && !pop_accept;
   assign pop_valid_o     = pop_valid_q;
   assign pop_data_o      = pop_data_q;
   assign ram_addr_o      = ram_addr_q;
   assign ram_din_o       = ram_din_q;
   assign ram_we_o        = ram_we_q;
   assign ram_opcode_o    = ram_opcode_q;
   assign count_o         = count_q;
   assign full_o          = full;
   assign empty_o         = empty;
   assign err_underflow_o = err_underflow_q;
   assign err_mode_o      = err_mode_q;

endmodule

// File: tb/tb_fifo_lifo_ctrl.sv
// Self-checking bench for fifo_lifo_ctrl with a registered-output RAM model and a pop scoreboard.
module tb_fifo_lifo_ctrl;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset, mode, push_valid, pop_req;
   logic [DATA_W-1:0] push_data;
   logic              push_ready, pop_valid;
   logic [DATA_W-1:0] pop_data, ram_din;
   logic [DATA_W-1:0] ram_dout = '0;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we, full, empty, err_underflow, err_mode;
   logic [3:0]        ram_opcode;
   logic [ADDR_W:0]   count;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] model_q [$];
   logic [DATA_W-1:0] exp_q [$];
   logic              b_mode;
   int                b_wr, b_rd;
   int                vectors = 0;
   int                miscompares = 0;

   fifo_lifo_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_i(clk), .reset_i(reset), .mode_i(mode),
      .push_valid_i(push_valid), .push_data_i(push_data), .push_ready_o(push_ready),
      .pop_req_i(pop_req), .pop_valid_o(pop_valid), .pop_data_o(pop_data),
      .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_we_o(ram_we),
      .ram_opcode_o(ram_opcode), .ram_dout_i(ram_dout),
      .count_o(count), .full_o(full), .empty_o(empty),
      .err_underflow_o(err_underflow), .err_mode_o(err_mode)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      if (ram_opcode[1:0] == 2'b10) ram_dout <= mem[ram_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1; push_valid = 1'b0; pop_req = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
      model_q.delete(); exp_q.delete();
      b_wr = 0; b_rd = 0; b_mode = mode;
   endtask

   task automatic do_push(input logic [DATA_W-1:0] d, output logic [ADDR_W-1:0] addr);
      int                waited;
      logic [ADDR_W-1:0] exp_addr;
      logic [3:0]        exp_op;
      waited = 0;
      addr = '0;
      push_valid = 1'b1; push_data = d;
      #1;
      while (push_ready !== 1'b1 && waited < 8) begin tick(); waited++; end
      vectors++;
      if (push_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL push_accept: push_ready=%b required 1", push_ready);
         push_valid = 1'b0;
         return;
      end
      exp_addr = b_mode ? ADDR_W'(model_q.size()) : ADDR_W'(b_wr);
      exp_op   = {1'b1, b_mode, 2'b01};
      tick();
      push_valid = 1'b0;
      vectors++;
      if ({ram_we, ram_opcode, ram_addr, ram_din} !== {1'b1, exp_op, exp_addr, d}) begin
         miscompares++;
         $display("FAIL push_cmd: we=%b op=%b addr=%0d din=%h required we=1 op=%b addr=%0d din=%h",
                  ram_we, ram_opcode, ram_addr, ram_din, exp_op, exp_addr, d);
      end
      addr = ram_addr;
      model_q.push_back(d);
      if (!b_mode) b_wr = (b_wr + 1) % DEPTH;
      tick();
      vectors++;
      if (count !== (ADDR_W+1)'(model_q.size())) begin
         miscompares++;
         $display("FAIL push_count: count=%0d required %0d", count, model_q.size());
      end
   endtask

   task automatic do_pop(input logic with_push, output logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] exp_d;
      logic [ADDR_W-1:0] exp_addr;
      logic [3:0]        exp_op;
      int                lat;
      exp_d = b_mode ? model_q.pop_back() : model_q.pop_front();
      exp_q.push_back(exp_d);
      exp_addr = b_mode ? ADDR_W'(model_q.size()) : ADDR_W'(b_rd);
      exp_op   = {1'b1, b_mode, 2'b10};
      pop_req = 1'b1;
      if (with_push) begin
         push_valid = 1'b1; push_data = 32'h0000_0088;
         #1;
         vectors++;
         if (push_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pop_priority: push_ready=%b required 0", push_ready);
         end
      end
      tick();
      pop_req = 1'b0; push_valid = 1'b0;
      vectors++;
      if ({ram_we, ram_opcode, ram_addr} !== {1'b0, exp_op, exp_addr}) begin
         miscompares++;
         $display("FAIL pop_cmd: we=%b op=%b addr=%0d required we=0 op=%b addr=%0d",
                  ram_we, ram_opcode, ram_addr, exp_op, exp_addr);
      end
      addr = ram_addr;
      if (!b_mode) b_rd = (b_rd + 1) % DEPTH;
      lat = 1;
      while (pop_valid !== 1'b1 && lat < 8) begin tick(); lat++; end
      exp_d = exp_q.pop_front();
      vectors++;
      if (pop_valid !== 1'b1 || lat != 3) begin
         miscompares++;
         $display("FAIL pop_latency: pop_valid=%b after %0d cycles required 1 after 3", pop_valid, lat);
      end
      vectors++;
      if (pop_data !== exp_d) begin
         miscompares++;
         $display("FAIL pop_data: got %h required %h", pop_data, exp_d);
      end
      vectors++;
      if (count !== (ADDR_W+1)'(model_q.size())) begin
         miscompares++;
         $display("FAIL pop_count: count=%0d required %0d", count, model_q.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; mode = 1'b0; push_valid = 1'b1; pop_req = 1'b0; push_data = '0;
      tick(); tick();
      vectors++;
      if (push_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready: push_ready=%b during reset required 0", push_ready);
      end
      push_valid = 1'b0;
      reset = 1'b0;
      tick();
      model_q.delete(); exp_q.delete(); b_wr = 0; b_rd = 0; b_mode = 1'b0;
      vectors++;
      if ({push_ready, pop_valid, pop_data, empty, full, err_underflow, err_mode}
          !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_user: ready=%b pv=%b pd=%h empty=%b full=%b eu=%b em=%b required 1 0 0 1 0 0 0",
                  push_ready, pop_valid, pop_data, empty, full, err_underflow, err_mode);
      end
      vectors++;
      if ({ram_we, ram_opcode, ram_addr, ram_din, count} !== '0) begin
         miscompares++;
         $display("FAIL reset_ram: we=%b op=%b addr=%0d din=%h count=%0d required all 0",
                  ram_we, ram_opcode, ram_addr, ram_din, count);
      end
   endtask

   task automatic test_fifo_fill();
      logic [ADDR_W-1:0] a;
      int                wrote;
      mode = 1'b0; b_mode = 1'b0;
      for (int i = 0; i < DEPTH; i++) do_push(32'hA0 + i, a);
      push_valid = 1'b1; push_data = 32'hEE;
      #1;
      vectors++;
      if ({full, empty, push_ready, count} !== {1'b1, 1'b0, 1'b0, 4'd8}) begin
         miscompares++;
         $display("FAIL full_flags: full=%b empty=%b ready=%b count=%0d required 1 0 0 8",
                  full, empty, push_ready, count);
      end
      wrote = 0;
      for (int i = 0; i < 3; i++) begin tick(); if (ram_we) wrote++; end
      push_valid = 1'b0;
      vectors++;
      if (wrote != 0) begin
         miscompares++;
         $display("FAIL full_no_write: %0d writes while full required 0", wrote);
      end
      for (int i = 0; i < DEPTH; i++) do_pop(1'b0, a);
      vectors++;
      if ({empty, full} !== 2'b10) begin
         miscompares++;
         $display("FAIL drained_flags: empty=%b full=%b required 1 0", empty, full);
      end
   endtask

   task automatic test_lifo();
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] want;
      mode = 1'b1;
      tick();
      b_mode = 1'b1;
      do_push(32'h11, a); do_push(32'h22, a); do_push(32'h33, a);
      for (int i = 0; i < 3; i++) begin
         do_pop(1'b0, a);
         want = ADDR_W'(2 - i);
         vectors++;
         if (a !== want) begin
            miscompares++;
            $display("FAIL lifo_read_addr: got %0d required %0d", a, want);
         end
      end
   endtask

   task automatic test_fifo_wrap();
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] want;
      mode = 1'b0;
      apply_reset();
      for (int i = 0; i < DEPTH; i++) do_push(32'hB0 + i, a);
      for (int i = 0; i < 5; i++) do_pop(1'b0, a);
      for (int i = 0; i < 5; i++) begin
         do_push(32'hC0 + i, a);
         want = ADDR_W'(i);
         vectors++;
         if (a !== want) begin
            miscompares++;
            $display("FAIL wrap_write_addr: got %0d required %0d", a, want);
         end
      end
      for (int i = 0; i < DEPTH; i++) do_pop(1'b0, a);
      vectors++;
      if ({count, empty} !== {4'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL wrap_drained: count=%0d empty=%b required 0 1", count, empty);
      end
   endtask

   task automatic test_underflow_priority();
      logic [ADDR_W-1:0] a;
      int                activity;
      pop_req = 1'b1;
      tick();
      pop_req = 1'b0;
      vectors++;
      if ({err_underflow, ram_we, ram_opcode} !== {1'b1, 1'b0, 4'b0000}) begin
         miscompares++;
         $display("FAIL underflow_pulse: eu=%b we=%b op=%b required 1 0 0000",
                  err_underflow, ram_we, ram_opcode);
      end
      activity = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (err_underflow || pop_valid || ram_opcode != 4'b0000) activity++;
      end
      vectors++;
      if (activity != 0) begin
         miscompares++;
         $display("FAIL underflow_quiet: %0d active cycles after the pulse required 0", activity);
      end
      do_push(32'h77, a);
      do_pop(1'b1, a);
      vectors++;
      if ({count, empty} !== {4'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL priority_count: count=%0d empty=%b required 0 1", count, empty);
      end
   endtask

   task automatic test_mode_change();
      logic [ADDR_W-1:0] a;
      mode = 1'b0;
      apply_reset();
      do_push(32'hD1, a); do_push(32'hD2, a); do_push(32'hD3, a);
      mode = 1'b1;
      tick();
      vectors++;
      if (err_mode !== 1'b1) begin
         miscompares++;
         $display("FAIL err_mode_pulse: err_mode=%b required 1", err_mode);
      end
      tick();
      vectors++;
      if (err_mode !== 1'b0) begin
         miscompares++;
         $display("FAIL err_mode_once: err_mode=%b required 0", err_mode);
      end
      for (int i = 0; i < 3; i++) do_pop(1'b0, a);
      b_mode = 1'b1;
      do_push(32'h55, a);
      do_pop(1'b0, a);
   endtask

   task automatic test_reset_in_read();
      logic [ADDR_W-1:0] a;
      int                spurious;
      mode = 1'b0;
      apply_reset();
      do_push(32'hE1, a); do_push(32'hE2, a);
      pop_req = 1'b1;
      tick();
      pop_req = 1'b0;
      reset = 1'b1;
      tick();
      vectors++;
      if ({pop_valid, count, empty, ram_we} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_in_read: pv=%b count=%0d empty=%b we=%b required 0 0 1 0",
                  pop_valid, count, empty, ram_we);
      end
      reset = 1'b0;
      spurious = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (pop_valid) spurious++; end
      vectors++;
      if (spurious != 0) begin
         miscompares++;
         $display("FAIL reset_no_pop: %0d pop_valid pulses required 0", spurious);
      end
      model_q.delete(); exp_q.delete(); b_wr = 0; b_rd = 0;
   endtask

   initial begin
      test_reset();
      test_fifo_fill();
      test_lifo();
      test_fifo_wrap();
      test_underflow_priority();
      test_mode_change();
      test_reset_in_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
